// File: rtl/wb_master_arbiter_if.sv
// Bus bundle between the two-requester Wishbone command arbiter and its
// environment (requesters plus the downstream Wishbone master interface).
//
// Signals
//   reqN_valid/addr/sel/we/wdata  requester N command (N = 0, 1)
//   reqN_ready/done/err/rdata     arbiter responses to requester N
//   m_start, m_address, m_selection, m_write, m_data_wr
//                                 command launched to the master interface
//   m_data_rd, m_active           read data / in-progress flag from it
//   busy, owner                   arbiter status
//
// Modports
//   master  the arbiter side
//   slave   the environment side (requesters and master interface)
interface wb_master_arbiter_if #(
  parameter int dw = 32,
  parameter int aw = 32
);
  logic          req0_valid;
  logic [aw-1:0] req0_addr;
  logic [3:0]    req0_sel;
  logic          req0_we;
  logic [dw-1:0] req0_wdata;
  logic          req0_ready;
  logic          req0_done;
  logic          req0_err;
  logic [dw-1:0] req0_rdata;

  logic          req1_valid;
  logic [aw-1:0] req1_addr;
  logic [3:0]    req1_sel;
  logic          req1_we;
  logic [dw-1:0] req1_wdata;
  logic          req1_ready;
  logic          req1_done;
  logic          req1_err;
  logic [dw-1:0] req1_rdata;

  logic          m_start;
  logic [aw-1:0] m_address;
  logic [3:0]    m_selection;
  logic          m_write;
  logic [dw-1:0] m_data_wr;
  logic [dw-1:0] m_data_rd;
  logic          m_active;

  logic          busy;
  logic          owner;

  modport master (
    input  req0_valid, req0_addr, req0_sel, req0_we, req0_wdata,
    output req0_ready, req0_done, req0_err, req0_rdata,
    input  req1_valid, req1_addr, req1_sel, req1_we, req1_wdata,
    output req1_ready, req1_done, req1_err, req1_rdata,
    output m_start, m_address, m_selection, m_write, m_data_wr,
    input  m_data_rd, m_active,
    output busy, owner
  );

  modport slave (
    output req0_valid, req0_addr, req0_sel, req0_we, req0_wdata,
    input  req0_ready, req0_done, req0_err, req0_rdata,
    output req1_valid, req1_addr, req1_sel, req1_we, req1_wdata,
    input  req1_ready, req1_done, req1_err, req1_rdata,
    input  m_start, m_address, m_selection, m_write, m_data_wr,
    output m_data_rd, m_active,
    input  busy, owner
  );
endinterface

// File: rtl/wb_master_arbiter.sv
// Two-requester round-robin arbiter in front of a Wishbone master interface.
// A granted command is latched, launched with a one-cycle m_start, and the
// arbiter then waits for m_active to rise (bounded by LAUNCH_TO cycles) and
// fall again before returning a done/err pulse to the owning requester.
//
// Ports
//   wb_clk    clock, all state on the rising edge
//   wb_rst_n  asynchronous active-low reset
//   bus       wb_master_arbiter_if.master (requester and master-side signals)
//
// State      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for a requester while the master interface is idle
// LAUNCH     | m_start pulse for the latched command
// WAIT_ACT   | waiting for m_active to rise, launch timeout counter running
// WAIT_DONE  | transfer in progress, waiting for m_active to fall
// RESP       | done/err pulse to the owner
module wb_master_arbiter #(
  parameter int dw        = 32,
  parameter int aw        = 32,
  parameter int LAUNCH_TO = 8   // 1..15, fits the 4-bit launch counter
) (
  input  logic                wb_clk,
  input  logic                wb_rst_n,
  wb_master_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_ACT  = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;

  // The counter starts at 0 on the first WAIT_ACT cycle, so the timeout
  // fires on the cycle where its next value would reach LAUNCH_TO.
  localparam logic [3:0] TO_LAST = 4'(LAUNCH_TO - 1);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          owner_q, owner_d;
  logic          err_q, err_d;
  logic [aw-1:0] addr_q, addr_d;
  logic [3:0]    sel_q, sel_d;
  logic          we_q, we_d;
  logic [dw-1:0] wdata_q, wdata_d;
  logic [dw-1:0] rdata0_q, rdata0_d;
  logic [dw-1:0] rdata1_q, rdata1_d;

  logic grant0, grant1;
  logic ready0, ready1;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant0 = bus.req0_valid && (!bus.req1_valid || last_q);
    grant1 = bus.req1_valid && (!bus.req0_valid || !last_q);
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    owner_d  = owner_q;
    err_d    = err_q;
    addr_d   = addr_q;
    sel_d    = sel_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    ready0   = 1'b0;
    ready1   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A transfer still active on the master side (e.g. left over from
        // before a reset) blocks any new grant. Ready is combinational with
        // valid so a requester may withdraw at any time before the grant;
        // it is held low while reset is asserted.
        if (wb_rst_n && !bus.m_active && (grant0 || grant1)) begin
          ready0  = grant0;
          ready1  = grant1;
          owner_d = grant1;
          last_d  = grant1;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = LAUNCH;
          if (grant1) begin
            addr_d  = bus.req1_addr;
            sel_d   = bus.req1_sel;
            we_d    = bus.req1_we;
            wdata_d = bus.req1_wdata;
          end else begin
            addr_d  = bus.req0_addr;
            sel_d   = bus.req0_sel;
            we_d    = bus.req0_we;
            wdata_d = bus.req0_wdata;
          end
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT_ACT;
      end
      WAIT_ACT: begin
        if (bus.m_active) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WAIT_DONE: begin
        if (!bus.m_active) begin
          if (!we_q) begin
            if (owner_q) rdata1_d = bus.m_data_rd;
            else         rdata0_d = bus.m_data_rd;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.req0_ready  = ready0;
  assign bus.req1_ready  = ready1;
  assign bus.req0_done   = (state_q == RESP) && !owner_q;
  assign bus.req1_done   = (state_q == RESP) && owner_q;
  assign bus.req0_err    = (state_q == RESP) && !owner_q && err_q;
  assign bus.req1_err    = (state_q == RESP) && owner_q && err_q;
  assign bus.req0_rdata  = rdata0_q;
  assign bus.req1_rdata  = rdata1_q;

  assign bus.m_start     = (state_q == LAUNCH);
  assign bus.m_address   = addr_q;
  assign bus.m_selection = sel_q;
  assign bus.m_write     = we_q;
  assign bus.m_data_wr   = wdata_q;

  assign bus.busy        = (state_q != IDLE);
  assign bus.owner       = owner_q;

endmodule
